// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with store FIFO and pollable STATUS register.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        TX,
  output logic        Busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          r_ovf;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_data_hit, w_stat_hit, w_full, w_empty, w_wr, w_push, w_last, w_pop;
  logic [3:0]    w_cnt_sat;
  logic [31:0]   w_status;
  always_comb begin
    w_data_hit = Addr == BASE_ADDR;
    w_stat_hit = Addr == BASE_ADDR + 32'd4;
    w_full     = r_count == (AW+1)'(FIFO_DEPTH);
    w_empty    = r_count == '0;
    w_wr       = MemWrite && w_data_hit;
    w_push     = w_wr && !w_full;
    w_last     = r_cnt == CW'(CLKS_PER_BIT - 1);
    w_pop      = !w_empty && (r_state == IDLE || (r_state == STOP && w_last));
    w_cnt_sat  = (32'(r_count) > 32'd15) ? 4'd15 : 4'(r_count);
    w_status   = {24'd0, w_cnt_sat, r_ovf, Busy, w_empty, w_full};
    Sel        = w_data_hit || w_stat_hit;
    ReadData   = (MemRead && w_stat_hit) ? w_status : '0;
    Busy       = r_state != IDLE;
    TX         = r_tx;
  end
  // Storage is not reset: pointers and count define validity, so stale bytes are unreachable.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= WriteData[7:0];
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf   <= (w_wr && w_full) ? 1'b1 : (MemWrite && w_stat_hit && WriteData[3]) ? 1'b0 : r_ovf;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd];
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= START;
            r_tx    <= 1'b0;
          end
        end
        START: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          if (w_last) begin
            r_idx   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          if (w_last) begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 3'd1;
            r_state <= (r_idx == 3'd7) ? STOP : DATA;
            r_tx    <= (r_idx == 3'd7) ? 1'b1 : r_shift[1];
          end
        end
        default: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          if (w_last) begin
            // Back-to-back frames: a queued byte starts right after the stop bit.
            if (w_pop) r_shift <= r_mem[r_rd];
            r_idx   <= '0;
            r_state <= w_pop ? START : IDLE;
            r_tx    <= !w_pop;
          end
        end
      endcase
    end
  end
endmodule
